video_timing_gen: RTL

//  Parametrised raster timing generator, successor to the fixed 638-pixel test-pattern timing.

---
 rtl/video_timing_gen.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Parametrised raster timing generator. It divides clk down to a pixel
//   enable and runs horizontal/vertical counters. From those counters it
//   produces sync/blank, active-area coordinates, line/frame strobes and a
//   free-running frame counter. It supports PAL/NTSC vertical sets and a
//   scandouble mode. Mode inputs are only sampled at a frame boundary.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   pal          in   1 = PAL vertical set, 0 = NTSC
//   scandouble   in   1 = doubled line rate (vertical values x2, faster ce)
//   ce_pix       out  pixel clock enable, one clk wide
//   hc, vc       out  raw horizontal / vertical counters
//   x, y         out  active coordinates (x = hc, y = vc >> scandouble)
//   de           out  display enable (~hblank & ~vblank)
//   hblank, vblank, hsync, vsync   out  timing signals
//   line_start   out  one-clk pulse when hc wraps to 0
//   frame_start  out  one-clk pulse when hc and vc both wrap to 0
//   frame_cnt    out  frame counter, increments on every frame_start
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned FRAME_W  = 10,
    parameter int unsigned PIX_DIV  = 1,
    parameter int unsigned H_TOTAL  = 638,
    parameter int unsigned H_ACT    = 529,
    parameter int unsigned HS_START = 544,
    parameter int unsigned HS_END   = 590,
    parameter int unsigned V_TOT_P  = 312,
    parameter int unsigned V_ACT_P  = 300,
    parameter int unsigned VS_ST_P  = 304,
    parameter int unsigned VS_EN_P  = 308,
    parameter int unsigned V_TOT_N  = 262,
    parameter int unsigned V_ACT_N  = 240,
    parameter int unsigned VS_ST_N  = 245,
    parameter int unsigned VS_EN_N  = 248,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pal,
    input  logic               scandouble,
    output logic               ce_pix,
    output logic [CNT_W-1:0]   hc,
    output logic [CNT_W-1:0]   vc,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               de,
    output logic               hblank,
    output logic               vblank,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned DIV_W = $clog2(2 * PIX_DIV) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST_SD = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST_SS = DIV_W'(2 * PIX_DIV - 1);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] HS_ST_C  = CNT_W'(HS_START);
    localparam logic [CNT_W-1:0] HS_EN_C  = CNT_W'(HS_END);

    // Selects the PAL or NTSC value and doubles it in scandouble mode.
    function automatic logic [CNT_W-1:0] v_sel(input int unsigned p_val,
                                               input int unsigned n_val,
                                               input logic p, input logic s);
        logic [CNT_W-1:0] base;
        base = p ? CNT_W'(p_val) : CNT_W'(n_val);
        return base << s;
    endfunction

    logic             started;   // low until the first clk after reset release
    logic             pal_q;
    logic             sd_q;
    logic             eff_sd;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_last;

    logic             h_wrap;
    logic             v_wrap;
    logic             frame_wrap;
    logic [CNT_W-1:0] v_last;
    logic [CNT_W-1:0] hc_nxt;
    logic [CNT_W-1:0] vc_nxt;
    logic             pal_nxt;
    logic             sd_nxt;
    logic [CNT_W-1:0] va_nxt;
    logic [CNT_W-1:0] vss_nxt;
    logic [CNT_W-1:0] vse_nxt;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        // The mode registers are not loaded until the first clk. On that clk
        // the divider already follows the live scandouble pin.
        eff_sd   = started ? sd_q : scandouble;
        div_last = eff_sd ? DIV_LAST_SD : DIV_LAST_SS;

        v_last     = v_sel(V_TOT_P, V_TOT_N, pal_q, sd_q) - 1'b1;
        h_wrap     = (hc == H_LAST);
        v_wrap     = (vc >= v_last);
        frame_wrap = h_wrap & v_wrap;

        hc_nxt = h_wrap ? '0 : hc + 1'b1;
        vc_nxt = vc;
        if (h_wrap) begin
            vc_nxt = v_wrap ? '0 : vc + 1'b1;
        end

        // The registered outputs describe the position after the edge.
        // At a frame wrap they must use the mode that is being latched.
        pal_nxt = frame_wrap ? pal : pal_q;
        sd_nxt  = frame_wrap ? scandouble : sd_q;
        va_nxt  = v_sel(V_ACT_P, V_ACT_N, pal_nxt, sd_nxt);
        vss_nxt = v_sel(VS_ST_P, VS_ST_N, pal_nxt, sd_nxt);
        vse_nxt = v_sel(VS_EN_P, VS_EN_N, pal_nxt, sd_nxt);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started     <= 1'b0;
            pal_q       <= 1'b0;
            sd_q        <= 1'b0;
            div_cnt     <= '0;
            ce_pix      <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            started <= 1'b1;
            if (!started) begin
                pal_q <= pal;
                sd_q  <= scandouble;
            end

            // A greater-or-equal compare recovers cleanly if the period shrinks.
            if (div_cnt >= div_last) begin
                div_cnt <= '0;
                ce_pix  <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
                ce_pix  <= 1'b0;
            end

            line_start  <= 1'b0;
            frame_start <= 1'b0;

            if (ce_pix) begin
                hc          <= hc_nxt;
                vc          <= vc_nxt;
                line_start  <= h_wrap;
                frame_start <= frame_wrap;
                if (frame_wrap) begin
                    pal_q     <= pal;
                    sd_q      <= scandouble;
                    frame_cnt <= frame_cnt + 1'b1;
                end

                hblank <= (hc_nxt >= H_ACT_C);
                vblank <= (vc_nxt >= va_nxt);
                hsync  <= ((hc_nxt >= HS_ST_C) && (hc_nxt < HS_EN_C)) ? SYNC_POL : ~SYNC_POL;

                // vsync edges line up with the hsync leading edge.
                if (hc_nxt == HS_ST_C) begin
                    if (vc_nxt == vss_nxt) begin
                        vsync <= SYNC_POL;
                    end else if (vc_nxt == vse_nxt) begin
                        vsync <= ~SYNC_POL;
                    end
                end
            end
        end
    end

    assign x  = hc;
    assign y  = vc >> sd_q;
    assign de = ~hblank & ~vblank;

endmodule
